// File: rtl/lpm_and_seq_pkg.sv
// Shared types and sizing helpers for the lpm_and_sequencer slice.
package lpm_and_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int beats(input int size, input int chunk);
    return (size + chunk - 1) / chunk;
  endfunction

  // One extra bit so the counter can hold BEATS itself without wrapping.
  function automatic int cnt_w(input int b);
    return $clog2(b) + 1;
  endfunction

endpackage

// File: rtl/lpm_and_sequencer_and.sv
// lpm_and primitive: bitwise AND across lpm_size buses of lpm_width bits.
module lpm_and #(
  parameter int lpm_width = 8,
  parameter int lpm_size  = 2
) (
  input  logic [lpm_size*lpm_width-1:0] data,
  output logic [lpm_width-1:0]          result
);

  for (genvar i = 0; i < lpm_width; i++) begin : g_bit
    logic [lpm_size-1:0] col;
    for (genvar j = 0; j < lpm_size; j++) begin : g_bus
      assign col[j] = data[j*lpm_width + i];
    end
    assign result[i] = &col;
  end

endmodule

// File: rtl/lpm_and_sequencer.sv
// Folds LPM_SIZE buses through a CHUNK-wide lpm_and, one beat per cycle.
// Optional LPM_AND_SEQ_EARLY_EXIT_EN: finish as soon as the accumulator hits zero.
module lpm_and_sequencer
  import lpm_and_seq_pkg::*;
#(
  parameter int LPM_WIDTH = 8,
  parameter int LPM_SIZE  = 8,
  parameter int CHUNK     = 2
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LPM_SIZE*LPM_WIDTH-1:0] in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LPM_WIDTH-1:0]          out_result,
  output logic                          busy
);

  localparam int BEATS  = beats(LPM_SIZE, CHUNK);
  localparam int CNT_W  = cnt_w(BEATS);
  localparam int OP_W   = LPM_SIZE * LPM_WIDTH;
  localparam int BEAT_W = CHUNK * LPM_WIDTH;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_t               state_q, state_d;
  logic [OP_W-1:0]      opnd_q, opnd_d;
  logic [LPM_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     beat_q, beat_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [LPM_WIDTH-1:0] out_result_q, out_result_d;
  logic                 busy_q, busy_d;

  logic [BEATS*BEAT_W-1:0]          opnd_pad;
  logic [BEATS-1:0][BEAT_W-1:0]     beat_vec;
  logic [BEAT_W-1:0]                chunk_data;
  logic [LPM_WIDTH-1:0]             beat_and;
  logic [LPM_WIDTH-1:0]             acc_nxt;
  logic                             early;

  // Buses past LPM_SIZE read as all-ones so the last beat needs no masking.
  always_comb begin
    opnd_pad           = '1;
    opnd_pad[OP_W-1:0] = opnd_q;
  end

  assign beat_vec = opnd_pad;

  always_comb begin
    chunk_data = beat_vec[0];
    for (int b = 0; b < BEATS; b++) begin
      if (beat_q == CNT_W'(b)) chunk_data = beat_vec[b];
    end
  end

  lpm_and #(
    .lpm_width (LPM_WIDTH),
    .lpm_size  (CHUNK)
  ) u_and (
    .data   (chunk_data),
    .result (beat_and)
  );

  assign acc_nxt = acc_q & beat_and;

`ifdef LPM_AND_SEQ_EARLY_EXIT_EN
  assign early = (acc_nxt == '0);
`else
  assign early = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    opnd_d       = opnd_q;
    acc_d        = acc_q;
    beat_d       = beat_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    busy_d       = busy_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opnd_d     = in_data;
          acc_d      = '1;
          beat_d     = '0;
          state_d    = RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      RUN: begin
        acc_d  = acc_nxt;
        beat_d = beat_q + CNT_W'(1);
        if (beat_q == LAST_BEAT || early) begin
          state_d      = DONE;
          out_valid_d  = 1'b1;
          out_result_d = acc_nxt;
        end
      end
      DONE: begin
        // Return to IDLE only; the next accept needs a fresh edge there.
        if (out_ready) begin
          state_d      = IDLE;
          out_valid_d  = 1'b0;
          out_result_d = '0;
          in_ready_d   = 1'b1;
          busy_d       = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        in_ready_d   = 1'b1;
        out_valid_d  = 1'b0;
        out_result_d = '0;
        busy_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      opnd_q       <= '0;
      acc_q        <= '1;
      beat_q       <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      opnd_q       <= opnd_d;
      acc_q        <= acc_d;
      beat_q       <= beat_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      busy_q       <= busy_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_lpm_and_sequencer.sv
// Bench for lpm_and_sequencer: an 8x8 chunk-2 instance and a 5-bus remainder instance.
module tb_lpm_and_sequencer;

  logic        clock;
  logic        reset_n;
  logic        in_valid [2];
  logic        in_ready [2];
  logic [63:0] dat      [2];
  logic        out_valid[2];
  logic        out_ready[2];
  logic [7:0]  out_result[2];
  logic        busy     [2];

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  lpm_and_sequencer #(.LPM_WIDTH(8), .LPM_SIZE(8), .CHUNK(2)) u_a (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(dat[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_result(out_result[0]), .busy(busy[0]));

  lpm_and_sequencer #(.LPM_WIDTH(8), .LPM_SIZE(5), .CHUNK(2)) u_b (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(dat[1][39:0]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_result(out_result[1]), .busy(busy[1]));

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  function automatic int sz(input int i);
    return (i == 0) ? 8 : 5;
  endfunction

  // Reference result: plain AND of all buses.
  function automatic logic [7:0] ref_res(input logic [63:0] d, input int s);
    logic [7:0] r = 8'hFF;
    for (int j = 0; j < s; j++) r &= d[j*8 +: 8];
    return r;
  endfunction

  // Number of processing edges: all beats, or up to the beat where the running AND first zeroes.
  function automatic int ref_nb(input logic [63:0] d, input int s);
    logic [7:0] r = 8'hFF;
    int nb = (s + 1) / 2;
`ifdef LPM_AND_SEQ_EARLY_EXIT_EN
    for (int j = s - 1; j >= 0; j--) begin
      r = 8'hFF;
      for (int k = 0; k <= j; k++) r &= d[k*8 +: 8];
      if (r == 8'h00) nb = j / 2 + 1;
    end
`else
    r = d[7:0];
`endif
    return nb;
  endfunction

  // Model: 0 = waiting for operand, 1 = counting down processing edges, 2 = result held.
  int         m_ph  [2];
  int         m_left[2];
  logic [7:0] m_res [2];

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) m_ph[i] <= 0;
      else begin
        case (m_ph[i])
          0: if (in_valid[i]) begin
            m_ph[i]   <= 1;
            m_left[i] <= ref_nb(dat[i], sz(i));
            m_res[i]  <= ref_res(dat[i], sz(i));
          end
          1: begin
            m_left[i] <= m_left[i] - 1;
            if (m_left[i] == 1) m_ph[i] <= 2;
          end
          default: if (out_ready[i]) m_ph[i] <= 0;
        endcase
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("u%0d in_ready", i),   32'(in_ready[i]),   32'(m_ph[i] == 0));
        check($sformatf("u%0d out_valid", i),  32'(out_valid[i]),  32'(m_ph[i] == 2));
        check($sformatf("u%0d busy", i),       32'(busy[i]),       32'(m_ph[i] != 0));
        check($sformatf("u%0d out_result", i), 32'(out_result[i]), 32'((m_ph[i] == 2) ? m_res[i] : 8'h00));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Accept one operand, count edges until out_valid, then take the result if out_ready is high.
  task automatic run_op(input int sel, input logic [63:0] d, input logic [7:0] er,
                        input int ee, input string nm);
    int n = 0;
    dat[sel]      = d;
    in_valid[sel] = 1'b1;
    step();
    in_valid[sel] = 1'b0;
    check({nm, " busy after accept"}, 32'(busy[sel]), 32'd1);
    while (!out_valid[sel] && n < 20) begin
      step();
      n++;
    end
    check({nm, " edges to valid"}, 32'(n), 32'(ee));
    check({nm, " result"}, 32'(out_result[sel]), 32'(er));
    if (out_ready[sel]) begin
      step();
      check({nm, " in_ready after exit"}, 32'(in_ready[sel]), 32'd1);
    end
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
      dat[i]       = '1;
    end
    step();
    step();
    chk_en  = 1;
    reset_n = 1'b1;
    check("reset in_ready",   32'(in_ready[0]),   32'd1);
    check("reset out_valid",  32'(out_valid[0]),  32'd0);
    check("reset out_result", 32'(out_result[0]), 32'd0);
    check("reset busy",       32'(busy[0]),       32'd0);

    run_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 4, "all_ff");
    run_op(0, 64'hFFFF_F0FF_FFFF_FFFF, 8'hF0, 4, "bus5_f0");
    run_op(0, 64'hF0FF_FFFF_FFFF_FF0F, 8'h00, 4, "bus0_0f_bus7_f0");

    // Backpressure: result held, new operands ignored.
    out_ready[0] = 1'b0;
    run_op(0, 64'hFFFF_F0FF_FFFF_FFFF, 8'hF0, 4, "bp");
    in_valid[0] = 1'b1;
    dat[0]      = 64'h0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("bp result stable", 32'(out_result[0]), 32'hF0);
      check("bp in_ready low",  32'(in_ready[0]),   32'd0);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    step();
    check("bp exit in_ready",  32'(in_ready[0]),  32'd1);
    check("bp exit out_valid", 32'(out_valid[0]), 32'd0);

    run_op(1, {24'hFFFFFF, 8'h7F, 8'hFF, 8'hFF, 8'hFE, 8'hFF}, 8'h7E, 3, "rem_s5");

    // Reset two beats into an operand that would zero the accumulator.
    dat[0]      = 64'hFF00_FFFF_FFFF_FFFF;
    in_valid[0] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    step();
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("midrun rst in_ready",  32'(in_ready[0]),  32'd1);
    check("midrun rst out_valid", 32'(out_valid[0]), 32'd0);
    run_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 4, "after_rst");

`ifdef LPM_AND_SEQ_EARLY_EXIT_EN
    run_op(0, 64'hFFFF_FFFF_FFFF_FF00, 8'h00, 1, "bus0_zero");
`else
    run_op(0, 64'hFFFF_FFFF_FFFF_FF00, 8'h00, 4, "bus0_zero");
`endif

    // in_valid held high: one accept per IDLE visit, checked by the model.
    dat[0]      = 64'hFFFF_FFFF_7FFF_FFFF;
    in_valid[0] = 1'b1;
    for (int k = 0; k < 14; k++) step();
    in_valid[0] = 1'b0;
    n = 0;
    while (!in_ready[0] && n < 20) begin
      step();
      n++;
    end
    check("drain to idle", 32'(in_ready[0]), 32'd1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
